l2_instruction_line_fill: RTL
=============================

// Module: l2_instruction_line_fill
// PURPOSE
//  Sits directly downstream of INSTRUCTION_CACHE on its L2 miss port. Accepts a miss address over valid/ready,
//  fetches the full 512-bit line from a narrow memory bus in MEM_BUS_WIDTH beats, assembles the line and
//  returns it to the cache over valid/ready. One outstanding miss at a time.
// PARAMETERS
//  ADDRESS_WIDTH   32   byte-address width; the cache-side miss address is ADDRESS_WIDTH-2 bits (word address)
//  L2_BUS_WIDTH    512  line width returned to the cache
//  MEM_BUS_WIDTH   32   memory response beat width; must divide L2_BUS_WIDTH (elaboration error otherwise)
//  BEATS = L2_BUS_WIDTH/MEM_BUS_WIDTH (16 at defaults); counter width = clog2(BEATS)
// PORTS
//  CLK                      in   1                  clock, rising edge
//  RESET_N                  in   1                  asynchronous, active-low reset
//  ADDRESS_TO_L2_VALID_INS  in   1                  miss request from cache
//  ADDRESS_TO_L2_READY_INS  out  1                  block can accept a miss
//  ADDRESS_TO_L2_INS        in   ADDRESS_WIDTH-2    word address of miss
//  DATA_FROM_L2_VALID_INS   out  1                  assembled line available
//  DATA_FROM_L2_READY_INS   in   1                  cache accepts line
//  DATA_FROM_L2_INS         out  L2_BUS_WIDTH       assembled line
//  MEM_REQ_VALID            out  1                  line read request to memory
//  MEM_REQ_READY            in   1                  memory accepts request
//  MEM_REQ_ADDRESS          out  ADDRESS_WIDTH      line-aligned byte address
//  MEM_RESP_VALID           in   1                  response beat valid
//  MEM_RESP_READY           out  1                  block accepts beat
//  MEM_RESP_DATA            in   MEM_BUS_WIDTH      response beat
// BEHAVIOUR
//  Reset (async assert, sync deassert by CLK): state=IDLE, beat counter=0, line register=0; all valids low,
//   ADDRESS_TO_L2_READY_INS=1 once out of reset, MEM_RESP_READY=0, MEM_REQ_ADDRESS=0, DATA_FROM_L2_INS=0.
//  FSM IDLE -> REQUEST -> FILL -> RESPOND -> IDLE. All outputs registered or decoded from state only.
//  IDLE: ADDRESS_TO_L2_READY_INS=1. On VALID&&READY latch line address = ADDRESS_TO_L2_INS with low
//   clog2(L2_BUS_WIDTH/32) bits (4 at defaults) cleared; go REQUEST. READY low in every other state.
//  REQUEST: MEM_REQ_VALID=1, MEM_REQ_ADDRESS={line word addr,2'b00}; held stable until MEM_REQ_READY;
//   on handshake go FILL with beat counter=0.
//  FILL: MEM_RESP_READY=1. Each MEM_RESP_VALID beat k written to line[k*MEM_BUS_WIDTH +: MEM_BUS_WIDTH],
//   counter++. On beat BEATS-1 go RESPOND; counter wraps to 0. Beats outside FILL are not acknowledged.
//  RESPOND: DATA_FROM_L2_VALID_INS=1, DATA_FROM_L2_INS stable until DATA_FROM_L2_READY_INS; on handshake
//   go IDLE (no same-cycle acceptance of the next miss; next miss accepted earliest one cycle later).
//  Latency (zero-wait memory, READY always high): accept at cycle 0, MEM_REQ_VALID cycle 1, beats cycles
//   2..BEATS+1, DATA_FROM_L2_VALID_INS cycle BEATS+2 (18 at defaults).
//  Backpressure/gaps: MEM_RESP_VALID gaps stall FILL without data change; stalled RESPOND holds data.
//  Reset mid-operation: any state returns to IDLE immediately; partial line discarded; later stray beats ignored.
//  Address bits below line granularity never reach MEM_REQ_ADDRESS.
// CONFIGURATION
//  LINE_BUFFER_HIT_EN defined: keep last completed line + its line address + valid bit (valid cleared by reset).
//   A miss in IDLE whose line address matches a valid buffered line goes straight to RESPOND (no memory
//   request); DATA_FROM_L2_VALID_INS asserts the cycle after acceptance. Buffer updated on every fill.
//  LINE_BUFFER_HIT_EN undefined: every miss goes to memory; no buffer storage or compare logic exists.
// TESTING
//  1 Reset: RESET_N=0 mid-FILL (beat 7) -> all valids 0 async; after release READY_INS=1, next miss refetches all 16 beats.
//  2 Basic fill: miss 30'h0000_0013, mem READY=1, beats 32'h0..32'hF -> MEM_REQ_ADDRESS=32'h40,
//    line word k = k, DATA_FROM_L2_VALID_INS at cycle 18.
//  3 Stalls: MEM_REQ_READY low 3 cycles, beat gap after beat 5, DATA_FROM_L2_READY_INS low 4 cycles
//    -> address/line held stable, no extra/duplicated beats, single line handshake.
//  4 Back-to-back: second miss asserted during RESPOND -> not accepted until cycle after line handshake.
//  5 LINE_BUFFER_HIT_EN: repeat miss 30'h13 after fill -> no MEM_REQ_VALID, line returned 1 cycle after
//    accept; miss 30'h23 -> normal 16-beat fill, MEM_REQ_ADDRESS=32'h80.
//  6 Stray beat: MEM_RESP_VALID=1 in IDLE with 32'hDEAD_BEEF -> MEM_RESP_READY=0, next line unaffected.

Source files
------------

// File: rtl/l2_instruction_line_fill.sv
// L2 instruction line fill: accepts one cache miss, fetches the line in narrow memory beats and
// returns the assembled line. Define LINE_BUFFER_HIT_EN to serve repeat misses from the last line.
module l2_instruction_line_fill #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned L2_BUS_WIDTH  = 512,
   parameter int unsigned MEM_BUS_WIDTH = 32
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     ADDRESS_TO_L2_VALID_INS,
   output logic                     ADDRESS_TO_L2_READY_INS,
   input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
   output logic                     DATA_FROM_L2_VALID_INS,
   input  logic                     DATA_FROM_L2_READY_INS,
   output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
   output logic                     MEM_REQ_VALID,
   input  logic                     MEM_REQ_READY,
   output logic [ADDRESS_WIDTH-1:0] MEM_REQ_ADDRESS,
   input  logic                     MEM_RESP_VALID,
   output logic                     MEM_RESP_READY,
   input  logic [MEM_BUS_WIDTH-1:0] MEM_RESP_DATA
);

   localparam int unsigned Beats   = L2_BUS_WIDTH / MEM_BUS_WIDTH;
   localparam int unsigned CntW    = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned WordW   = ADDRESS_WIDTH - 2;
   localparam int unsigned OffW    = $clog2(L2_BUS_WIDTH / 32);
   localparam logic [WordW-1:0] LineMask = ~WordW'((1 << OffW) - 1);
   localparam logic [CntW-1:0]  LastBeat = CntW'(Beats - 1);

   if ((L2_BUS_WIDTH % MEM_BUS_WIDTH) != 0) begin : gen_bad_width
      $error("MEM_BUS_WIDTH must divide L2_BUS_WIDTH");
   end

   typedef enum logic [1:0] {StIdle, StRequest, StFill, StRespond} state_e;

   state_e                   state_q;
   logic [CntW-1:0]          cnt_q;
   logic [L2_BUS_WIDTH-1:0]  line_q;
   logic [WordW-1:0]         line_addr_q;
   logic [WordW-1:0]         miss_line_addr;

   assign miss_line_addr = ADDRESS_TO_L2_INS & LineMask;

`ifdef LINE_BUFFER_HIT_EN
   // line_q doubles as the buffered line: it is only rewritten by a fill, and a fill always
   // completes (or reset intervenes) before the next IDLE compare.
   logic buf_valid_q;
   logic buf_hit;
   assign buf_hit = buf_valid_q && (miss_line_addr == line_addr_q);
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         line_q      <= '0;
         line_addr_q <= '0;
`ifdef LINE_BUFFER_HIT_EN
         buf_valid_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ADDRESS_TO_L2_VALID_INS) begin
                  line_addr_q <= miss_line_addr;
`ifdef LINE_BUFFER_HIT_EN
                  if (buf_hit) begin
                     state_q <= StRespond;
                  end else begin
                     state_q     <= StRequest;
                     buf_valid_q <= 1'b0;
                  end
`else
                  state_q <= StRequest;
`endif
               end
            end
            StRequest: begin
               if (MEM_REQ_READY) begin
                  state_q <= StFill;
                  cnt_q   <= '0;
               end
            end
            StFill: begin
               if (MEM_RESP_VALID) begin
                  line_q[cnt_q*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] <= MEM_RESP_DATA;
                  if (cnt_q == LastBeat) begin
                     cnt_q   <= '0;
                     state_q <= StRespond;
`ifdef LINE_BUFFER_HIT_EN
                     buf_valid_q <= 1'b1;
`endif
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            StRespond: begin
               if (DATA_FROM_L2_READY_INS) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ADDRESS_TO_L2_READY_INS = (state_q == StIdle);
   assign MEM_REQ_VALID           = (state_q == StRequest);
   assign MEM_RESP_READY          = (state_q == StFill);
   assign DATA_FROM_L2_VALID_INS  = (state_q == StRespond);
   assign MEM_REQ_ADDRESS         = {line_addr_q, 2'b00};
   assign DATA_FROM_L2_INS        = line_q;

endmodule
